// File: rtl/pkt_addr_dec.sv
// Ingress packet address decoder: matches frame headers against four port
// addresses and streams matching frames into the per-port FIFOs.
// Optional feature macro: ADDR_DEC_BCAST_EN (0xFF header broadcasts to all ports).
module pkt_addr_dec #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned FIFO_SIZE = 64,
   localparam int unsigned CW       = $clog2(FIFO_SIZE) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sw_enable,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                valid_in,
   output logic                ready_out,
   input  logic [4*DATA_W-1:0] port_addr,
   input  logic [4*CW-1:0]     fifo_index,
   output logic                fifo_en,
   output logic [3:0]          wr_en,
   output logic [DATA_W-1:0]   data_out,
   output logic [15:0]         drop_cnt,
   output logic                busy
);

   localparam int unsigned NPORT = 4;
   localparam int unsigned RW    = CW + 1;
   localparam int unsigned DCW   = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LEN      = 3'd1,
      PAYLOAD  = 3'd2,
      DROP_LEN = 3'd3,
      DROP     = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [NPORT-1:0]    mask, mask_nxt;
   logic [NPORT-1:0]    hdr_mask;
   logic [NPORT-1:0]    room;
   logic [NPORT-1:0]    wr_nxt;
   logic [DATA_W-1:0]   cnt, cnt_nxt;
   logic [DCW-1:0]      drop_nxt;
   logic                accept;

   // Room per port: occupancy plus the write still in flight must stay below depth
   always_comb begin
      room = '0;
      for (int k = 0; k < NPORT; k++) begin
         room[k] = (RW'(fifo_index[k*CW +: CW]) + RW'(wr_en[k])) < RW'(FIFO_SIZE);
      end
   end

   // Header match; duplicate addresses give a multi-hot mask
   always_comb begin
      hdr_mask = '0;
      for (int k = 0; k < NPORT; k++) begin
         hdr_mask[k] = (data_in == port_addr[k*DATA_W +: DATA_W]);
      end
`ifdef ADDR_DEC_BCAST_EN
      if (data_in == '1) begin
         hdr_mask = '1;
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask;
      cnt_nxt   = cnt;
      wr_nxt    = '0;
      drop_nxt  = drop_cnt;
      ready_out = 1'b0;
      accept    = 1'b0;

      unique case (state)
         IDLE:               ready_out = sw_enable && (&room);
         LEN, PAYLOAD:       ready_out = sw_enable && (&(room | ~mask));
         DROP_LEN, DROP:     ready_out = sw_enable;
         default:            ready_out = 1'b0;
      endcase
      if (rst) begin
         ready_out = 1'b0;
      end
      accept = valid_in && ready_out;

      if (accept) begin
         unique case (state)
            IDLE: begin
               mask_nxt = hdr_mask;
               if (hdr_mask != '0) begin
                  wr_nxt    = hdr_mask;
                  state_nxt = LEN;
               end else begin
                  state_nxt = DROP_LEN;
                  if (drop_cnt != '1) begin
                     drop_nxt = drop_cnt + DCW'(1);
                  end
               end
            end
            LEN: begin
               wr_nxt    = mask;
               cnt_nxt   = data_in;
               state_nxt = (data_in == '0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
               wr_nxt  = mask;
               cnt_nxt = cnt - DATA_W'(1);
               if (cnt == DATA_W'(1)) begin
                  state_nxt = IDLE;
               end
            end
            DROP_LEN: begin
               cnt_nxt   = data_in;
               state_nxt = (data_in == '0) ? IDLE : DROP;
            end
            DROP: begin
               cnt_nxt = cnt - DATA_W'(1);
               if (cnt == DATA_W'(1)) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mask     <= '0;
         cnt      <= '0;
         wr_en    <= '0;
         fifo_en  <= 1'b0;
         data_out <= '0;
         drop_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mask     <= mask_nxt;
         cnt      <= cnt_nxt;
         wr_en    <= wr_nxt;
         fifo_en  <= sw_enable;
         drop_cnt <= drop_nxt;
         busy     <= (state_nxt != IDLE);
         if (accept) begin
            data_out <= data_in;
         end
      end
   end

endmodule

// File: tb/tb_pkt_addr_dec.sv
// Scoreboard bench for pkt_addr_dec: frame-level reference model feeds an
// expected-write queue that a negedge monitor drains; FIFO occupancy is modelled.
module tb_pkt_addr_dec;

   localparam int DATA_W    = 8;
   localparam int FIFO_SIZE = 64;
   localparam int CW        = $clog2(FIFO_SIZE) + 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                sw_enable = 1'b1;
   logic [DATA_W-1:0]   data_in = '0;
   logic                valid_in = 1'b0;
   logic                ready_out;
   logic [4*DATA_W-1:0] port_addr = {8'h40, 8'h30, 8'h20, 8'h10};
   logic [4*CW-1:0]     fifo_index;
   logic                fifo_en;
   logic [3:0]          wr_en;
   logic [DATA_W-1:0]   data_out;
   logic [15:0]         drop_cnt;
   logic                busy;

   pkt_addr_dec #(.DATA_W(DATA_W), .FIFO_SIZE(FIFO_SIZE)) dut (
      .clk(clk), .rst(rst), .sw_enable(sw_enable), .data_in(data_in),
      .valid_in(valid_in), .ready_out(ready_out), .port_addr(port_addr),
      .fifo_index(fifo_index), .fifo_en(fifo_en), .wr_en(wr_en),
      .data_out(data_out), .drop_cnt(drop_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stalls = 0;
   int   acc_cnt = 0;
   int   exp_drop = 0;
   bit   rand_gaps = 0;
   bit   rand_sw = 0;

   // Downstream FIFO occupancy model: counts writes, drains when enabled
   int   occ[4] = '{0, 0, 0, 0};
   int   load_val[4] = '{0, 0, 0, 0};
   bit   load_en = 0;
   bit   drain_en = 1;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 4; k++) begin
         if (load_en) occ[k] <= load_val[k];
         else occ[k] <= occ[k] + int'(wr_en[k])
                        - ((drain_en && occ[k] > 0 && $urandom_range(0, 1) == 1) ? 1 : 0);
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) fifo_index[k*CW +: CW] = CW'(occ[k]);
   end

   // Monitor: every observed write must be the next expected one, on time, and fit
   always @(negedge clk) begin
      if (wr_en != 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: wr_en=%b data=%h cyc=%0d", wr_en, data_out, cyc);
         end else begin
            e = exp_q.pop_front();
            if (wr_en !== e.mask || data_out !== e.data || cyc != e.cyc || fifo_en !== 1'b1) begin
               errors++;
               $display("FAIL write: got wr_en=%b data=%h cyc=%0d fifo_en=%b, expected wr_en=%b data=%h cyc=%0d fifo_en=1",
                        wr_en, data_out, cyc, fifo_en, e.mask, e.data, e.cyc);
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
               checks++;
               if (occ[k] >= FIFO_SIZE) begin
                  errors++;
                  $display("FAIL overflow port %0d: occupancy %0d, required below %0d", k, occ[k], FIFO_SIZE);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
      end
   endtask

   function automatic logic [3:0] ref_mask(input logic [7:0] h, input logic [31:0] pa);
      logic [3:0] m = 4'b0000;
      for (int k = 0; k < 4; k++) if (pa[k*8 +: 8] == h) m[k] = 1'b1;
`ifdef ADDR_DEC_BCAST_EN
      if (h == 8'hFF) m = 4'b1111;
`endif
      return m;
   endfunction

   // Present one byte until accepted; record the expected write on acceptance
   task automatic send_byte(input logic [7:0] b, input logic [3:0] m);
      bit done = 0;
      int budget = 0;
      while (!done) begin
         @(negedge clk);
         valid_in  = !(rand_gaps && $urandom_range(0, 3) == 0);
         sw_enable = !(rand_sw && $urandom_range(0, 7) == 0);
         data_in   = b;
         #1;
         if (valid_in && ready_out) begin
            done = 1;
            acc_cnt++;
            if (m != 4'b0000) exp_q.push_back('{m, b, cyc + 1});
         end else begin
            stalls++;
         end
         budget++;
         if (!done && budget > 3000) begin
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted in %0d cycles", b, budget);
            done = 1;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] fr[$]);
      logic [3:0] m = ref_mask(fr[0], port_addr);
      foreach (fr[i]) begin
         send_byte(fr[i], m);
         if (i == 0 && m == 4'b0000 && exp_drop < 16'hFFFF) exp_drop++;
      end
   endtask

   task automatic stop_stream();
      @(negedge clk);
      valid_in  = 1'b0;
      sw_enable = 1'b1;
      #1;
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
   endtask

   logic [7:0] q[$];

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", int'(ready_out), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_fifo_en", int'(fifo_en), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;

      // Unicast to port 1
      q = '{8'h20, 8'h03, 8'hA1, 8'hA2, 8'hA3};
      stalls = 0;
      send_frame(q);
      stop_stream();
      chk("unicast_stalls", stalls, 0);
      chk("unicast_drop", int'(drop_cnt), 0);
      settle();

      // Unmatched frame is dropped without stalling
      q = '{8'h55, 8'h02, 8'h01, 8'h02};
      stalls = 0;
      send_frame(q);
      chk("drop_busy_mid", int'(busy), 1);
      stop_stream();
      chk("drop_stalls", stalls, 0);
      chk("drop_cnt_1", int'(drop_cnt), 1);
      chk("drop_busy_end", int'(busy), 0);

      // Zero-length frame then back-to-back frame
      stalls = 0;
      q = '{8'h10, 8'h00};
      send_frame(q);
      q = '{8'h30, 8'h01, 8'hEE};
      send_frame(q);
      stop_stream();
      chk("b2b_stalls", stalls, 0);
      settle();

      // Backpressure: port 1 one slot from full
      drain_en = 0;
      @(negedge clk);
      load_val = '{0, 63, 0, 0};
      load_en = 1;
      @(negedge clk);
      load_en = 0;
      acc_cnt = 0;
      q = '{8'h20, 8'h02, 8'hB1, 8'hB2};
      fork
         send_frame(q);
         begin
            repeat (10) @(negedge clk);
            #2;
            chk("bp_accepted", acc_cnt, 1);
            chk("bp_ready", int'(ready_out), 0);
            drain_en = 1;
         end
      join
      stop_stream();
      chk("bp_total_accepted", acc_cnt, 4);
      settle();

      // Broadcast header (dropped unless the broadcast feature is built in)
      q = '{8'hFF, 8'h01, 8'h5A};
      send_frame(q);
      stop_stream();
      chk("bcast_drop_cnt", int'(drop_cnt), exp_drop);
      settle();

      // Reset during the third payload byte of a 6-byte frame
      send_byte(8'h40, 4'b1000);
      send_byte(8'h04, 4'b1000);
      send_byte(8'hC1, 4'b1000);
      send_byte(8'hC2, 4'b1000);
      @(negedge clk);
      rst = 1'b1;
      data_in = 8'hC3;
      valid_in = 1'b1;
      #1;
      chk("rst_mid_ready", int'(ready_out), 0);
      @(negedge clk);
      #1;
      exp_drop = 0;
      chk("rst_mid_wr_en", int'(wr_en), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_fifo_en", int'(fifo_en), 0);
      chk("rst_mid_data_out", int'(data_out), 0);
      chk("rst_mid_drop_cnt", int'(drop_cnt), 0);
      rst = 1'b0;
      valid_in = 1'b0;
      q = '{8'h30, 8'h01, 8'h77};
      send_frame(q);
      stop_stream();
      settle();

      // Randomized frames, addresses (with duplicates), gaps and enable drops
      rand_gaps = 1;
      rand_sw = 1;
      for (int f = 0; f < 150; f++) begin
         if (f % 25 == 0) begin
            for (int k = 0; k < 4; k++) port_addr[k*8 +: 8] = 8'(8'h10 + $urandom_range(0, 3));
         end
         q = {};
         if ($urandom_range(0, 5) == 0) q.push_back(8'hFF);
         else q.push_back(8'(8'h10 + $urandom_range(0, 4)));
         q.push_back(8'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6)));
         for (int i = 0; i < int'(q[1]); i++) q.push_back(8'($urandom));
         send_frame(q);
         if ($urandom_range(0, 3) == 0) stop_stream();
      end
      stop_stream();
      settle();
      chk("final_drop_cnt", int'(drop_cnt), exp_drop);
      chk("final_busy", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
